// File: rtl/mipi_csi_pkg.sv
// Shared CSI-2 data-type codes, controller state encoding and type helpers
// for the RAW depacker sequencing logic.
package mipi_csi_pkg;

  localparam logic [7:0] DT_FS    = 8'h00;
  localparam logic [7:0] DT_FE    = 8'h01;
  localparam logic [7:0] DT_LS    = 8'h02;
  localparam logic [7:0] DT_LE    = 8'h03;
  localparam logic [7:0] DT_RAW10 = 8'h2B;
  localparam logic [7:0] DT_RAW12 = 8'h2C;
  localparam logic [7:0] DT_RAW14 = 8'h2D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FORWARD,
    ST_DROP,
    ST_GAP
  } state_e;

  // Expects the virtual-channel bits already masked off.
  function automatic logic is_raw_supported(input logic [7:0] dt);
    return (dt == DT_RAW10) || (dt == DT_RAW12) || (dt == DT_RAW14);
  endfunction

endpackage

// File: rtl/mipi_rx_hdr_skid.sv
// One-entry holding register for a packet header that arrives while the
// controller cannot take it yet; flags headers that have nowhere to go.
module mipi_rx_hdr_skid #(
  parameter int WC_WIDTH = 16
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                hdr_valid_i,
  input  logic [7:0]          hdr_dt_i,
  input  logic [WC_WIDTH-1:0] hdr_wc_i,
  input  logic                bypass_i,
  input  logic                store_en_i,
  input  logic                pop_i,
  output logic                valid_o,
  output logic [7:0]          dt_o,
  output logic [WC_WIDTH-1:0] wc_o,
  output logic                overlap_o
);

  logic                valid_q, valid_d;
  logic [7:0]          dt_q;
  logic [WC_WIDTH-1:0] wc_q;
  logic                push;

  // A full slot can be refilled in the same cycle it is being consumed.
  assign push      = hdr_valid_i && !bypass_i && store_en_i && (!valid_q || pop_i);
  assign overlap_o = hdr_valid_i && !bypass_i && !push;

  always_comb begin
    valid_d = valid_q;
    if (pop_i) valid_d = 1'b0;
    if (push)  valid_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) valid_q <= 1'b0;
    else            valid_q <= valid_d;
  end

  // NOTE: the header fields carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      dt_q <= hdr_dt_i;
      wc_q <= hdr_wc_i;
    end
  end

  assign valid_o = valid_q;
  assign dt_o    = dt_q;
  assign wc_o    = wc_q;

endmodule

// File: rtl/mipi_rx_depacker_ctrl.sv
// Header-driven sequencer for the 4-lane RAW depacker: gates payload beats,
// enforces an inter-packet valid-low gap and tracks frame/line position.
module mipi_rx_depacker_ctrl
  import mipi_csi_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int WC_WIDTH   = 16,
  parameter int LINE_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  enable_i,
  input  logic                  header_valid_i,
  input  logic [7:0]            header_dt_i,
  input  logic [WC_WIDTH-1:0]   header_wc_i,
  input  logic                  payload_valid_i,
  input  logic [31:0]           payload_data_i,
  output logic                  depacker_valid_o,
  output logic [31:0]           depacker_data_o,
  output logic [2:0]            depacker_type_o,
  output logic                  frame_active_o,
  output logic                  frame_start_o,
  output logic                  frame_end_o,
  output logic                  line_end_o,
  output logic [LINE_WIDTH-1:0] line_count_o,
  output logic                  err_unsupported_o,
  output logic                  err_truncated_o,
  output logic                  err_overlap_o
);

  localparam int         BW       = WC_WIDTH - 1;
  localparam logic [2:0] GAP_LAST = 3'(GAP_CYCLES - 1);

  state_e                state_q, state_d;
  logic [BW-1:0]         beats_q, beats_d;
  logic [2:0]            gap_q, gap_d;
  logic                  started_q, started_d;
  logic                  frame_q, frame_d;
  logic [LINE_WIDTH-1:0] lines_q, lines_d;
  logic                  valid_q, valid_d;
  logic [31:0]           data_q, data_d;
  logic [2:0]            type_q, type_d;
  logic                  fs_q, fs_d, fe_q, fe_d, le_q, le_d;
  logic                  unsup_q, unsup_d, trunc_q, trunc_d, ovl_q, ovl_d;

  logic                  skid_valid, skid_ovl;
  logic [7:0]            skid_dt;
  logic [WC_WIDTH-1:0]   skid_wc;

  logic                  in_idle, hv, is_long, fwd_ok, drop, last_beat, pkt_done;
  logic [7:0]            hdt;
  logic [WC_WIDTH-1:0]   hwc;
  logic [WC_WIDTH:0]     wc_round;
  logic [BW-1:0]         beats_load;

  mipi_rx_hdr_skid #(.WC_WIDTH(WC_WIDTH)) u_skid (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .hdr_valid_i(header_valid_i),
    .hdr_dt_i   (header_dt_i),
    .hdr_wc_i   (header_wc_i),
    .bypass_i   (in_idle && !skid_valid),
    .store_en_i ((state_q == ST_GAP) || (in_idle && skid_valid)),
    .pop_i      (in_idle && skid_valid),
    .valid_o    (skid_valid),
    .dt_o       (skid_dt),
    .wc_o       (skid_wc),
    .overlap_o  (skid_ovl)
  );

  // A held header takes priority over a live one when IDLE is reached.
  assign in_idle    = (state_q == ST_IDLE);
  assign hv         = in_idle && (skid_valid || header_valid_i);
  assign hdt        = (skid_valid ? skid_dt : header_dt_i) & 8'h3F;
  assign hwc        = skid_valid ? skid_wc : header_wc_i;
  assign is_long    = (hdt >= 8'h10) && (hwc != '0);
  assign fwd_ok     = is_long && frame_q && is_raw_supported(hdt);
  assign drop       = is_long && !fwd_ok;
  assign wc_round   = {1'b0, hwc} + (WC_WIDTH+1)'(3);
  assign beats_load = wc_round[WC_WIDTH:2];
  assign last_beat  = (beats_q == BW'(1));
  // A stall before the first beat is a late payload, not a truncation.
  assign pkt_done   = payload_valid_i ? last_beat : started_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (hv && fwd_ok) state_d = ST_FORWARD;
                  else if (hv && drop) state_d = ST_DROP;
      ST_FORWARD: if (pkt_done) state_d = ST_GAP;
      ST_DROP:    if (pkt_done) state_d = ST_IDLE;
      ST_GAP:     if (gap_q == GAP_LAST) state_d = ST_IDLE;
    endcase
  end

  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    beats_d   = beats_q;
    gap_d     = '0;
    started_d = started_q;
    frame_d   = frame_q;
    lines_d   = lines_q;
    valid_d   = 1'b0;
    data_d    = '0;
    type_d    = type_q;
    fs_d      = 1'b0;
    fe_d      = 1'b0;
    le_d      = 1'b0;
    unsup_d   = 1'b0;
    trunc_d   = 1'b0;
    ovl_d     = skid_ovl;
    unique case (state_q)
      ST_IDLE: if (hv) begin
        if (hdt == DT_FS) begin
          if (enable_i) begin
            frame_d = 1'b1;
            fs_d    = 1'b1;
            lines_d = '0;
          end
        end else if (hdt == DT_FE) begin
          if (frame_q) begin
            frame_d = 1'b0;
            fe_d    = 1'b1;
          end
        end else if (fwd_ok || drop) begin
          beats_d   = beats_load;
          started_d = 1'b0;
          unsup_d   = drop;
          if (fwd_ok) type_d = hdt[2:0];
        end
      end
      ST_FORWARD, ST_DROP: begin
        if (payload_valid_i) begin
          started_d = 1'b1;
          beats_d   = beats_q - BW'(1);
          if (state_q == ST_FORWARD) begin
            valid_d = 1'b1;
            data_d  = payload_data_i;
            if (last_beat) begin
              le_d = 1'b1;
              if (lines_q != '1) lines_d = lines_q + LINE_WIDTH'(1);
            end
          end
        end else if (started_q) begin
          trunc_d = 1'b1;
        end
      end
      ST_GAP: gap_d = gap_q + 3'd1;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      beats_q   <= '0;
      gap_q     <= '0;
      started_q <= 1'b0;
      frame_q   <= 1'b0;
      lines_q   <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      type_q    <= DT_RAW10[2:0];
      fs_q      <= 1'b0;
      fe_q      <= 1'b0;
      le_q      <= 1'b0;
      unsup_q   <= 1'b0;
      trunc_q   <= 1'b0;
      ovl_q     <= 1'b0;
    end else begin
      beats_q   <= beats_d;
      gap_q     <= gap_d;
      started_q <= started_d;
      frame_q   <= frame_d;
      lines_q   <= lines_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      type_q    <= type_d;
      fs_q      <= fs_d;
      fe_q      <= fe_d;
      le_q      <= le_d;
      unsup_q   <= unsup_d;
      trunc_q   <= trunc_d;
      ovl_q     <= ovl_d;
    end
  end

  assign depacker_valid_o  = valid_q;
  assign depacker_data_o   = data_q;
  assign depacker_type_o   = type_q;
  assign frame_active_o    = frame_q;
  assign frame_start_o     = fs_q;
  assign frame_end_o       = fe_q;
  assign line_end_o        = le_q;
  assign line_count_o      = lines_q;
  assign err_unsupported_o = unsup_q;
  assign err_truncated_o   = trunc_q;
  assign err_overlap_o     = ovl_q;

endmodule

// File: tb/tb_mipi_rx_depacker_ctrl.sv
// Directed bench: a packet-level model predicts the forwarded beat stream and
// event counts; a negedge monitor checks every output cycle against it.
module tb_mipi_rx_depacker_ctrl;

  localparam int GAP = 2;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        header_valid_i = 1'b0;
  logic [7:0]  header_dt_i = '0;
  logic [15:0] header_wc_i = '0;
  logic        payload_valid_i = 1'b0;
  logic [31:0] payload_data_i = '0;
  logic        depacker_valid_o;
  logic [31:0] depacker_data_o;
  logic [2:0]  depacker_type_o;
  logic        frame_active_o, frame_start_o, frame_end_o, line_end_o;
  logic [15:0] line_count_o;
  logic        err_unsupported_o, err_truncated_o, err_overlap_o;

  mipi_rx_depacker_ctrl #(.GAP_CYCLES(GAP), .WC_WIDTH(16), .LINE_WIDTH(16)) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .enable_i         (enable_i),
    .header_valid_i   (header_valid_i),
    .header_dt_i      (header_dt_i),
    .header_wc_i      (header_wc_i),
    .payload_valid_i  (payload_valid_i),
    .payload_data_i   (payload_data_i),
    .depacker_valid_o (depacker_valid_o),
    .depacker_data_o  (depacker_data_o),
    .depacker_type_o  (depacker_type_o),
    .frame_active_o   (frame_active_o),
    .frame_start_o    (frame_start_o),
    .frame_end_o      (frame_end_o),
    .line_end_o       (line_end_o),
    .line_count_o     (line_count_o),
    .err_unsupported_o(err_unsupported_o),
    .err_truncated_o  (err_truncated_o),
    .err_overlap_o    (err_overlap_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- packet-level model ----------------
  typedef struct packed { logic [31:0] d; logic [2:0] t; } beat_t;
  typedef enum int { M_NONE, M_FWD, M_DROP } mmode_e;

  beat_t  exp_q[$];
  mmode_e m_mode = M_NONE;
  int     m_left = 0;
  bit     m_started = 0;
  bit     m_frame = 0;
  int     m_lines = 0;
  logic [2:0] m_type = 3'h3;
  int exp_fs = 0, exp_fe = 0, exp_le = 0, exp_unsup = 0, exp_trunc = 0, exp_ovl = 0;

  task automatic model_hdr(input logic [7:0] dt, input logic [15:0] wc);
    logic [7:0] d6;
    d6 = dt & 8'h3F;
    if (d6 == 8'h00) begin
      if (enable_i) begin m_frame = 1; m_lines = 0; exp_fs++; end
    end else if (d6 == 8'h01) begin
      if (m_frame) begin m_frame = 0; exp_fe++; end
    end else if (d6 >= 8'h10 && wc != 0) begin
      m_left = (int'(wc) + 3) / 4;
      m_started = 0;
      if (m_frame && (d6 == 8'h2B || d6 == 8'h2C || d6 == 8'h2D)) begin
        m_mode = M_FWD;
        m_type = d6[2:0];
      end else begin
        m_mode = M_DROP;
        exp_unsup++;
      end
    end
  endtask

  // ---------------- monitor ----------------
  bit chk_en = 1;
  int vcount = 0;
  int first_valid_cyc = -1;
  int low_run = 0;
  bit seen_valid = 0;
  logic [2:0] last_type = '0;
  int cnt_fs = 0, cnt_fe = 0, cnt_le = 0, cnt_unsup = 0, cnt_trunc = 0, cnt_ovl = 0;

  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      low_run = 0;
      seen_valid = 0;
    end else begin
      if (frame_start_o)     cnt_fs++;
      if (frame_end_o)       cnt_fe++;
      if (line_end_o)        cnt_le++;
      if (err_unsupported_o) cnt_unsup++;
      if (err_truncated_o)   cnt_trunc++;
      if (err_overlap_o)     cnt_ovl++;
      if (chk_en) begin
        if (depacker_valid_o) begin
          vcount++;
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (seen_valid && low_run > 0) begin
            n_chk++;
            if (low_run < GAP) begin
              n_err++;
              $display("FAIL gap_len: got %0d low cycles, expected >= %0d", low_run, GAP);
            end
          end
          if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", depacker_data_o);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("beat_data", depacker_data_o, e.d);
            check("beat_type", 32'(depacker_type_o), 32'(e.t));
          end
          last_type = depacker_type_o;
          seen_valid = 1;
          low_run = 0;
        end else begin
          check("data_zero_when_idle", depacker_data_o, 32'h0);
          low_run++;
        end
      end
    end
  end

  // ---------------- stimulus helpers (called just after a posedge) ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic send_hdr(input logic [7:0] dt, input logic [15:0] wc);
    header_valid_i = 1; header_dt_i = dt; header_wc_i = wc;
    model_hdr(dt, wc);
    @(posedge clk_i); #1;
    header_valid_i = 0;
  endtask

  task automatic beat(input logic [31:0] d);
    payload_valid_i = 1; payload_data_i = d;
    if (m_left > 0) begin
      m_started = 1;
      if (m_mode == M_FWD) exp_q.push_back('{d: d, t: m_type});
      m_left--;
      if (m_left == 0) begin
        if (m_mode == M_FWD) begin m_lines++; exp_le++; end
        m_mode = M_NONE;
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic end_payload();
    payload_valid_i = 0; payload_data_i = '0;
    if (m_left > 0 && m_started) exp_trunc++;
    m_left = 0; m_started = 0; m_mode = M_NONE;
  endtask

  task automatic send_beats(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) beat(base + 32'(i));
    end_payload();
  endtask

  task automatic checkpoint(input string tag);
    check({tag, ":line_count"},   32'(line_count_o), 32'(m_lines));
    check({tag, ":frame_active"}, 32'(frame_active_o), 32'(m_frame));
    check({tag, ":n_frame_start"}, cnt_fs, exp_fs);
    check({tag, ":n_frame_end"},  cnt_fe, exp_fe);
    check({tag, ":n_line_end"},   cnt_le, exp_le);
    check({tag, ":n_unsupported"}, cnt_unsup, exp_unsup);
    check({tag, ":n_truncated"},  cnt_trunc, exp_trunc);
    check({tag, ":n_overlap"},    cnt_ovl, exp_ovl);
    check({tag, ":beats_pending"}, exp_q.size(), 0);
  endtask

  int first_beat_cyc, v0;

  initial begin
    idle(3);
    @(posedge clk_i); #1;
    reset_n_i = 1;
    idle(2);
    check("rst:valid", 32'(depacker_valid_o), 0);
    check("rst:data", depacker_data_o, 0);
    check("rst:type", 32'(depacker_type_o), 3);
    check("rst:frame_active", 32'(frame_active_o), 0);
    check("rst:line_count", 32'(line_count_o), 0);
    enable_i = 1;

    // T1: RAW10 800 bytes -> 200 beats
    send_hdr(8'h00, 16'd0);
    idle(2);
    send_hdr(8'h2B, 16'd800);
    first_beat_cyc = cyc;
    send_beats(200, 32'h1000_0000);
    idle(6);
    checkpoint("t1");
    check("t1:latency", first_valid_cyc - first_beat_cyc, 1);
    check("t1:vcount", vcount, 200);
    check("t1:type_raw10", 32'(last_type), 3);
    check("t1:line_count_lit", 32'(line_count_o), 1);

    // T2: RAW12 6 bytes -> 2 beats, then FE
    send_hdr(8'h00, 16'd0);
    send_hdr(8'h2C, 16'd6);
    beat(32'hAABBCCDD);
    beat(32'h11223344);
    end_payload();
    idle(4);
    check("t2:type_raw12", 32'(last_type), 4);
    send_hdr(8'h01, 16'd0);
    idle(2);
    checkpoint("t2");
    check("t2:frame_active_lit", 32'(frame_active_o), 0);
    check("t2:vcount", vcount, 202);

    // T3: RAW8 inside a frame is dropped
    send_hdr(8'h00, 16'd0);
    send_hdr(8'h2A, 16'd16);
    send_beats(4, 32'h3000_0000);
    idle(3);
    checkpoint("t3");
    check("t3:vcount", vcount, 202);
    check("t3:unsup_lit", cnt_unsup, 1);

    // T4: RAW14 40 bytes truncated after 6 beats
    send_hdr(8'h2D, 16'd40);
    send_beats(6, 32'h4000_0000);
    idle(6);
    checkpoint("t4");
    check("t4:vcount", vcount, 208);
    check("t4:trunc_lit", cnt_trunc, 1);
    check("t4:line_count_lit", 32'(line_count_o), 0);

    // T5: header mid-FORWARD is discarded; header in GAP becomes the next line
    send_hdr(8'h2B, 16'd16);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        header_valid_i = 1; header_dt_i = 8'h2C; header_wc_i = 16'd8;
        exp_ovl++;
      end
      beat(32'h5000_0000 + 32'(i));
      header_valid_i = 0;
    end
    end_payload();
    send_hdr(8'h2B, 16'd12);
    idle(5);
    send_beats(3, 32'h5100_0000);
    idle(6);
    checkpoint("t5");
    check("t5:line_count_lit", 32'(line_count_o), 2);
    check("t5:overlap_lit", cnt_ovl, 1);

    // Boundary: wc = 0xFFFF -> 16384 beats
    v0 = vcount;
    send_hdr(8'h2B, 16'hFFFF);
    send_beats(16384, 32'h6000_0000);
    idle(6);
    checkpoint("wcmax");
    check("wcmax:vcount", vcount - v0, 16384);

    // T6: enable low blocks FS; following line has no frame -> dropped
    send_hdr(8'h01, 16'd0);
    enable_i = 0;
    send_hdr(8'h00, 16'd0);
    send_hdr(8'h2B, 16'd8);
    send_beats(2, 32'h7000_0000);
    idle(3);
    checkpoint("t6");
    check("t6:unsup_lit", cnt_unsup, 2);
    check("t6:frame_active_lit", 32'(frame_active_o), 0);
    enable_i = 1;

    // T7: asynchronous reset in the middle of a RAW12 line
    send_hdr(8'h00, 16'd0);
    send_hdr(8'h2C, 16'd400);
    chk_en = 0;
    for (int i = 0; i < 10; i++) begin
      payload_valid_i = 1; payload_data_i = 32'h8000_0000 + 32'(i);
      @(posedge clk_i); #1;
    end
    #2;
    check("t7:valid_before_reset", 32'(depacker_valid_o), 1);
    reset_n_i = 0;
    #1;
    check("t7:valid", 32'(depacker_valid_o), 0);
    check("t7:data", depacker_data_o, 0);
    check("t7:type", 32'(depacker_type_o), 3);
    check("t7:frame_active", 32'(frame_active_o), 0);
    check("t7:line_count", 32'(line_count_o), 0);
    check("t7:pulses", {26'b0, frame_start_o, frame_end_o, line_end_o,
                        err_unsupported_o, err_truncated_o, err_overlap_o}, 0);
    payload_valid_i = 0; payload_data_i = '0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    reset_n_i = 1;
    m_frame = 0; m_lines = 0; m_mode = M_NONE; m_left = 0; m_started = 0;
    exp_q.delete();
    chk_en = 1;
    idle(4);
    checkpoint("t7");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mipi_rx_depacker_ctrl.md
Name: mipi_rx_depacker_ctrl

Overview:
Sequences the 4-lane RAW depacker from decoded CSI-2 packet headers. It consumes short packets (FS/FE/LS/LE) and long-packet headers from the packet decoder and gates payload beats to the depacker for exactly ceil(word_count/4) cycles. It presents the 3-bit packet type and enforces a valid-low gap between packets so the depacker re-initialises its burst state. It also tracks frame and line position, drops unsupported or out-of-frame packets, and flags protocol errors.

Parameters:
GAP_CYCLES, 2, minimum cycles of depacker_valid_o low between consecutive forwarded long packets (range 1-7).
WC_WIDTH, 16, width of the word-count field and the byte counter.
LINE_WIDTH, 16, width of the line counter.

Ports:
clk_i  in  1  byte clock, shared with the packet decoder and depacker
reset_n_i  in  1  asynchronous, active-low reset
enable_i  in  1  accept new frames; sampled only in IDLE on a frame start
header_valid_i  in  1  one-cycle strobe; header fields valid
header_dt_i  in  8  data type (bits [5:0] meaningful; [7:6] is the virtual channel, ignored)
header_wc_i  in  WC_WIDTH  long packet: payload bytes; short packet: data field
payload_valid_i  in  1  payload beat valid
payload_data_i  in  32  4 payload bytes per beat
depacker_valid_o  out  1  data_valid to the depacker
depacker_data_o  out  32  payload to the depacker
depacker_type_o  out  3  packet_type to the depacker (data type & 3'h7)
frame_active_o  out  1  high from accepted FS to FE
frame_start_o  out  1  one-cycle pulse on accepted FS
frame_end_o  out  1  one-cycle pulse on FE while frame is active
line_end_o  out  1  one-cycle pulse after the last beat of a forwarded line
line_count_o  out  LINE_WIDTH  forwarded lines in the current frame
err_unsupported_o  out  1  pulse: long packet dropped (type not 0x2B/0x2C/0x2D, or no active frame)
err_truncated_o  out  1  pulse: payload_valid_i fell before the word count was consumed
err_overlap_o  out  1  pulse: header arrived while not in IDLE

Behaviour:
- Reset (asynchronous): all outputs 0; state IDLE; counters 0; depacker_type_o = 3'h3 (RAW10).
- States are IDLE, FORWARD, DROP and GAP.
- IDLE, on header_valid_i:
  - dt 0x00 (FS): if enable_i, set frame_active, pulse frame_start_o, clear line_count.
  - dt 0x01 (FE): if frame_active, clear it and pulse frame_end_o; otherwise no effect.
  - dt 0x02/0x03 (LS/LE): ignored.
  - dt 0x2B/0x2C/0x2D with frame_active and wc != 0: load beats = (wc+3)>>2, latch depacker_type_o, go to FORWARD.
  - Any other long dt (>= 0x10), or a long packet with no active frame: pulse err_unsupported_o, load beats, go to DROP.
  - wc == 0 on a long packet: no forwarding, no error.
- FORWARD:
  - Each payload_valid_i beat: depacker_valid_o = 1 and depacker_data_o = payload_data_i, registered (1-cycle latency); decrement beats.
  - After the last beat: depacker_valid_o low the next cycle, increment line_count_o, pulse line_end_o, go to GAP.
  - A payload_valid_i low cycle with beats remaining: pulse err_truncated_o, deassert valid, go to GAP; the line is not counted.
- DROP: consume beats with depacker_valid_o held 0; the same truncation rule applies, then go to IDLE (no GAP).
- GAP: hold depacker_valid_o = 0 for GAP_CYCLES, then go to IDLE.
  - A header arriving in GAP is held in a 1-entry skid register and processed on entry to IDLE.
  - A second header while the skid register is full is discarded and err_overlap_o pulses.
- Header during FORWARD/DROP: discarded, err_overlap_o pulses, the current packet continues.
- depacker_data_o is zero whenever depacker_valid_o is 0.
- line_count_o saturates at all-ones.
- beats counter width is WC_WIDTH-1; wc = 16'hFFFF gives 16384 beats.
- Deasserting enable_i mid-frame does not abort the frame; it blocks only the next FS.
- Reset mid-packet: immediate return to IDLE and valid low, with no error pulses.

Decomposition:
- Package mipi_csi_pkg holds:
  - data-type constants: DT_FS=8'h00, DT_FE=8'h01, DT_LS=8'h02, DT_LE=8'h03, DT_RAW10=8'h2B, DT_RAW12=8'h2C, DT_RAW14=8'h2D;
  - the state enum;
  - an is_raw_supported(dt) function.
- One natural sub-module, mipi_rx_hdr_skid: the 1-entry header skid register with overlap detection. The rest stays flat.

Test Plan:
- FS; RAW10 header wc=800; 200 payload beats -> 200 depacker_valid_o cycles starting 1 cycle after the first beat, type 3'h3, line_end_o pulse, line_count_o=1, then 2 idle cycles.
- FS; RAW12 wc=6 (2 beats: 0xAABBCCDD, 0x11223344) -> 2 valid beats with matching data, type 3'h4; FE -> frame_end_o, frame_active_o=0.
- RAW8 (0x2A) header wc=16 inside a frame -> err_unsupported_o pulse, 4 beats consumed, depacker_valid_o stays 0, line_count_o unchanged.
- RAW14 wc=40 with payload_valid_i dropping after 6 beats -> 6 valid beats, err_truncated_o pulse, line not counted, IDLE after GAP.
- Header mid-FORWARD -> err_overlap_o, current line completes; header during GAP -> processed as the next line after GAP, with no loss.
- enable_i=0 at FS -> frame_start_o absent; the following RAW10 line is dropped with err_unsupported_o. Assert reset_n_i mid-line -> all outputs 0 asynchronously.
